// File: rtl/spgd_pkg.sv
// Shared definitions for the SPGD perturbation sequencer and its update stage:
// default data widths, sequencer state encoding, LFSR taps and DAC saturation.
package spgd_pkg;

   localparam int SPGD_ADC_WIDTH = 12;
   localparam int SPGD_DAC_WIDTH = 14;

   // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_DRAW,
      ST_APPLY_P,
      ST_SETTLE_P,
      ST_SAMPLE_P,
      ST_APPLY_M,
      ST_SETTLE_M,
      ST_SAMPLE_M,
      ST_UPDATE,
      ST_COMMIT
   } state_t;

   // Signed add clamped to [0, 2^width-1]. Evaluated at 32 bits so an
   // unsigned code plus a signed perturbation can never wrap before clamping.
   function automatic logic [31:0] sat_add(input logic signed [31:0] a,
                                           input logic signed [31:0] b,
                                           input int                 width);
      logic signed [31:0] sum;
      logic signed [31:0] hi;
      sum = a + b;
      hi  = (32'sd1 <<< width) - 32'sd1;
      if (sum < 32'sd0)
         return 32'd0;
      else if (sum > hi)
         return hi;
      else
         return sum;
   endfunction

endpackage

// File: rtl/spgd_lfsr.sv
// 16-bit Fibonacci LFSR: shifts left with the tap parity fed into bit 0,
// stepping only when advance is asserted.
module spgd_lfsr
   import spgd_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_advance,
   output logic [15:0] o_state
);

   logic [15:0] r_lfsr;
   logic        w_feedback;

   assign w_feedback = ^(r_lfsr & LFSR_TAPS);

   // Shift register state; reloads the seed on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_lfsr <= SEED;
      else if (i_advance)
         r_lfsr <= {r_lfsr[14:0], w_feedback};
   end

   assign o_state = r_lfsr;

endmodule

// File: rtl/spgd_perturb_seq.sv
// SPGD perturbation sequencer: per iteration it draws a +/-DELTA per channel,
// drives U+dU, settles and samples J_p, drives U-dU, settles and samples J_m,
// holds everything steady for the combinational update stage, then commits
// the new operating point to both U and the DACs.
module spgd_perturb_seq
   import spgd_pkg::*;
#(
   parameter int                           ADC_WIDTH     = SPGD_ADC_WIDTH,
   parameter int                           DAC_WIDTH     = SPGD_DAC_WIDTH,
   parameter int                           SETTLE_CYCLES = 16,
   parameter logic [DAC_WIDTH-1:0]         DELTA_MAG     = 14'h0040,
   parameter logic [DAC_WIDTH-1:0]         INIT_U        = 14'h2000,
   parameter logic [15:0]                  LFSR_SEED     = 16'hACE1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic [ADC_WIDTH-1:0] adc_data,
   input  logic                 adc_valid,
   output logic [DAC_WIDTH-1:0] dac0,
   output logic [DAC_WIDTH-1:0] dac1,
   output logic                 dac_load,
   output logic [ADC_WIDTH-1:0] J_p,
   output logic [ADC_WIDTH-1:0] J_m,
   output logic [DAC_WIDTH-1:0] U0,
   output logic [DAC_WIDTH-1:0] U1,
   output logic [DAC_WIDTH-1:0] DELTA_U0,
   output logic [DAC_WIDTH-1:0] DELTA_U1,
   input  logic [DAC_WIDTH-1:0] new_U0,
   input  logic [DAC_WIDTH-1:0] new_U1,
   output logic                 iter_done,
   output logic [15:0]          iter_count,
   output logic                 busy
);

   localparam int                   CNT_W     = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0]     SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [DAC_WIDTH-1:0] NEG_DELTA = ~DELTA_MAG + 1'b1;

   state_t                 r_state;
   state_t                 w_next_state;
   logic                   w_lfsr_adv;
   logic [15:0]            w_lfsr;
   logic                   w_unused_lfsr;

   logic [DAC_WIDTH-1:0]   r_u        [2];
   logic [DAC_WIDTH-1:0]   r_du       [2];
   logic [DAC_WIDTH-1:0]   r_dac      [2];
   logic [DAC_WIDTH-1:0]   w_new_u    [2];
   logic [DAC_WIDTH-1:0]   w_dac_p    [2];
   logic [DAC_WIDTH-1:0]   w_dac_m    [2];
   logic [ADC_WIDTH-1:0]   r_jp;
   logic [ADC_WIDTH-1:0]   r_jm;
   logic [CNT_W-1:0]       r_settle_cnt;
   logic                   r_dac_load;
   logic                   r_iter_done;
   logic [15:0]            r_iter_count;

   spgd_lfsr #(
      .SEED      (LFSR_SEED)
   ) u_lfsr (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_advance (w_lfsr_adv),
      .o_state   (w_lfsr)
   );

   // Only the two low LFSR bits pick perturbation signs.
   assign w_unused_lfsr = ^w_lfsr[15:2];

   assign w_new_u[0] = new_U0;
   assign w_new_u[1] = new_U1;

   // Per-channel saturated U+dU and U-dU codes.
   for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      logic signed [31:0] w_u_s;
      logic signed [31:0] w_du_s;
      assign w_u_s       = {{(32-DAC_WIDTH){1'b0}}, r_u[gi]};
      assign w_du_s      = {{(32-DAC_WIDTH){r_du[gi][DAC_WIDTH-1]}}, r_du[gi]};
      assign w_dac_p[gi] = DAC_WIDTH'(sat_add(w_u_s, w_du_s, DAC_WIDTH));
      assign w_dac_m[gi] = DAC_WIDTH'(sat_add(w_u_s, -w_du_s, DAC_WIDTH));
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= ST_IDLE;
      else
         r_state <= w_next_state;
   end

   // Next-state decode; enable is only looked at in IDLE and COMMIT so a
   // started iteration always runs to completion.
   always_comb begin
      w_next_state = r_state;
      w_lfsr_adv   = 1'b0;
      case (r_state)
         ST_IDLE:     if (enable) w_next_state = ST_DRAW;
         ST_DRAW:     begin
                         w_lfsr_adv   = 1'b1;
                         w_next_state = ST_APPLY_P;
                      end
         ST_APPLY_P:  w_next_state = ST_SETTLE_P;
         ST_SETTLE_P: if (r_settle_cnt == '0) w_next_state = ST_SAMPLE_P;
         ST_SAMPLE_P: if (adc_valid) w_next_state = ST_APPLY_M;
         ST_APPLY_M:  w_next_state = ST_SETTLE_M;
         ST_SETTLE_M: if (r_settle_cnt == '0) w_next_state = ST_SAMPLE_M;
         ST_SAMPLE_M: if (adc_valid) w_next_state = ST_UPDATE;
         ST_UPDATE:   w_next_state = ST_COMMIT;
         ST_COMMIT:   w_next_state = enable ? ST_DRAW : ST_IDLE;
         default:     w_next_state = ST_IDLE;
      endcase
   end

   // Datapath: perturbation draw, DAC writes, settle count, metric capture, commit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int ch = 0; ch < 2; ch++) begin
            r_u[ch]   <= INIT_U;
            r_du[ch]  <= '0;
            r_dac[ch] <= INIT_U;
         end
         r_jp         <= '0;
         r_jm         <= '0;
         r_settle_cnt <= '0;
         r_dac_load   <= 1'b0;
         r_iter_done  <= 1'b0;
         r_iter_count <= '0;
      end else begin
         r_dac_load  <= 1'b0;
         r_iter_done <= 1'b0;
         case (r_state)
            ST_DRAW: begin
               for (int ch = 0; ch < 2; ch++)
                  r_du[ch] <= w_lfsr[ch] ? NEG_DELTA : DELTA_MAG;
            end
            ST_APPLY_P: begin
               for (int ch = 0; ch < 2; ch++)
                  r_dac[ch] <= w_dac_p[ch];
               r_dac_load   <= 1'b1;
               r_settle_cnt <= SETTLE_LD;
            end
            ST_SETTLE_P, ST_SETTLE_M: begin
               if (r_settle_cnt != '0)
                  r_settle_cnt <= r_settle_cnt - 1'b1;
            end
            ST_SAMPLE_P: begin
               if (adc_valid)
                  r_jp <= adc_data;
            end
            ST_APPLY_M: begin
               for (int ch = 0; ch < 2; ch++)
                  r_dac[ch] <= w_dac_m[ch];
               r_dac_load   <= 1'b1;
               r_settle_cnt <= SETTLE_LD;
            end
            ST_SAMPLE_M: begin
               if (adc_valid)
                  r_jm <= adc_data;
            end
            ST_COMMIT: begin
               for (int ch = 0; ch < 2; ch++) begin
                  r_u[ch]   <= w_new_u[ch];
                  r_dac[ch] <= w_new_u[ch];
               end
               r_dac_load   <= 1'b1;
               r_iter_done  <= 1'b1;
               r_iter_count <= r_iter_count + 16'd1;
            end
            default: ;
         endcase
      end
   end

   assign dac0       = r_dac[0];
   assign dac1       = r_dac[1];
   assign dac_load   = r_dac_load;
   assign J_p        = r_jp;
   assign J_m        = r_jm;
   assign U0         = r_u[0];
   assign U1         = r_u[1];
   assign DELTA_U0   = r_du[0];
   assign DELTA_U1   = r_du[1];
   assign iter_done  = r_iter_done;
   assign iter_count = r_iter_count;
   assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_spgd_perturb_seq.sv
// Directed bench for spgd_perturb_seq at default parameters. Expected LFSR
// sign pattern from seed 16'hACE1 (current state drives the draw):
//   iter1 ACE1 -> d0=-64 d1=+64; iter2 59C3 -> -,-; iter3 B387 -> -,-.
module tb_spgd_perturb_seq;

   localparam int S = 16;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic [11:0] adc_data;
   logic        adc_valid;
   logic [13:0] dac0, dac1, U0, U1, DELTA_U0, DELTA_U1, new_U0, new_U1;
   logic        dac_load;
   logic [11:0] J_p, J_m;
   logic        iter_done;
   logic [15:0] iter_count;
   logic        busy;

   int n_pass  = 0;
   int n_total = 0;

   spgd_perturb_seq dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .adc_data   (adc_data),
      .adc_valid  (adc_valid),
      .dac0       (dac0),
      .dac1       (dac1),
      .dac_load   (dac_load),
      .J_p        (J_p),
      .J_m        (J_m),
      .U0         (U0),
      .U1         (U1),
      .DELTA_U0   (DELTA_U0),
      .DELTA_U1   (DELTA_U1),
      .new_U0     (new_U0),
      .new_U1     (new_U1),
      .iter_done  (iter_done),
      .iter_count (iter_count),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      enable    = 1'b0;
      adc_valid = 1'b0;
      adc_data  = 12'h000;
      new_U0    = 14'h2000;
      new_U1    = 14'h2000;
      rst_n     = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic wait_load(input string name);
      bit ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         tick();
         if (dac_load) begin ok = 1'b1; break; end
      end
      n_total++;
      if (!ok) $display("FAIL %s: dac_load timeout got 0 required 1", name);
      else n_pass++;
   endtask

   task automatic wait_done(input string name);
      bit ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         tick();
         if (iter_done) begin ok = 1'b1; break; end
      end
      n_total++;
      if (!ok) $display("FAIL %s: iter_done timeout got 0 required 1", name);
      else begin
         n_pass++;
         $display("commit: iter_count=%0d U0=%h U1=%h J_p=%h J_m=%h", iter_count, U0, U1, J_p, J_m);
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_total++; if (dac0 !== 14'h2000) $display("FAIL reset_dac0: got %h required 2000", dac0); else n_pass++;
      n_total++; if (dac1 !== 14'h2000) $display("FAIL reset_dac1: got %h required 2000", dac1); else n_pass++;
      n_total++; if ({U0, U1} !== {14'h2000, 14'h2000}) $display("FAIL reset_u: got %h %h required 2000 2000", U0, U1); else n_pass++;
      n_total++; if ({J_p, J_m} !== 24'h0) $display("FAIL reset_j: got %h %h required 0 0", J_p, J_m); else n_pass++;
      n_total++; if ({DELTA_U0, DELTA_U1} !== 28'h0) $display("FAIL reset_delta: got %h %h required 0 0", DELTA_U0, DELTA_U1); else n_pass++;
      n_total++; if ({dac_load, iter_done, busy} !== 3'b000) $display("FAIL reset_strobes: got %b required 000", {dac_load, iter_done, busy}); else n_pass++;
      n_total++; if (iter_count !== 16'h0) $display("FAIL reset_count: got %h required 0000", iter_count); else n_pass++;
   endtask

   task automatic test_first_draw();
      do_reset();
      adc_valid = 1'b1;
      adc_data  = 12'h100;
      enable    = 1'b1;
      tick();
      n_total++; if (busy !== 1'b1) $display("FAIL draw_busy: got %b required 1", busy); else n_pass++;
      tick();
      n_total++; if (DELTA_U0 !== 14'h3FC0) $display("FAIL draw_delta0: got %h required 3fc0", DELTA_U0); else n_pass++;
      n_total++; if (DELTA_U1 !== 14'h0040) $display("FAIL draw_delta1: got %h required 0040", DELTA_U1); else n_pass++;
      tick();
      n_total++; if (dac_load !== 1'b1) $display("FAIL apply_p_load: got %b required 1", dac_load); else n_pass++;
      n_total++; if ({dac0, dac1} !== {14'h1FC0, 14'h2040}) $display("FAIL apply_p_dac: got %h %h required 1fc0 2040", dac0, dac1); else n_pass++;
      tick();
      n_total++; if (dac_load !== 1'b0) $display("FAIL load_one_cycle: got %b required 0", dac_load); else n_pass++;
      enable = 1'b0;
      wait_load("first_apply_m");
      n_total++; if ({dac0, dac1} !== {14'h2040, 14'h1FC0}) $display("FAIL apply_m_dac: got %h %h required 2040 1fc0", dac0, dac1); else n_pass++;
      wait_done("first_commit");
   endtask

   task automatic test_settle_timing();
      int t_load = -1;
      int t_jp   = -1;
      int t_done = -1;
      do_reset();
      adc_valid = 1'b1;
      adc_data  = 12'h123;
      enable    = 1'b1;
      for (int k = 1; k <= 100; k++) begin
         tick();
         if (dac_load && t_load < 0) t_load = k;
         if (J_p == 12'h123 && t_jp < 0) t_jp = k;
         if (iter_done) begin t_done = k; break; end
      end
      enable = 1'b0;
      n_total++; if (t_jp - t_load != S + 1) $display("FAIL settle_to_capture: got %0d required %0d", t_jp - t_load, S + 1); else n_pass++;
      n_total++; if (t_done != 2 * S + 8) $display("FAIL iter_latency: got %0d required %0d", t_done, 2 * S + 8); else n_pass++;
   endtask

   task automatic test_update();
      int extra = 0;
      do_reset();
      new_U0    = 14'h2100;
      new_U1    = 14'h1F00;
      adc_valid = 1'b1;
      adc_data  = 12'h200;
      enable    = 1'b1;
      tick();
      enable = 1'b0;
      for (int k = 0; k < 100; k++) begin
         tick();
         if (J_p == 12'h200) adc_data = 12'h100;
         if (iter_done) break;
      end
      n_total++; if ({J_p, J_m} !== {12'h200, 12'h100}) $display("FAIL update_j: got %h %h required 200 100", J_p, J_m); else n_pass++;
      n_total++; if ({U0, dac0} !== {14'h2100, 14'h2100}) $display("FAIL commit_u0: got U0=%h dac0=%h required 2100", U0, dac0); else n_pass++;
      n_total++; if ({U1, dac1} !== {14'h1F00, 14'h1F00}) $display("FAIL commit_u1: got U1=%h dac1=%h required 1f00", U1, dac1); else n_pass++;
      n_total++; if (iter_count !== 16'd1) $display("FAIL commit_count: got %0d required 1", iter_count); else n_pass++;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (iter_done) extra++;
      end
      n_total++; if (extra != 0) $display("FAIL iter_done_once: got %0d extra pulses required 0", extra); else n_pass++;
   endtask

   task automatic test_saturation();
      do_reset();
      adc_valid = 1'b1;
      adc_data  = 12'h080;
      new_U0    = 14'h3FF0;
      new_U1    = 14'h0010;
      enable    = 1'b1;
      wait_done("sat_iter1");
      n_total++; if ({U0, U1} !== {14'h3FF0, 14'h0010}) $display("FAIL sat_setup_u: got %h %h required 3ff0 0010", U0, U1); else n_pass++;
      new_U0 = 14'h0010;
      new_U1 = 14'h3FF0;
      wait_load("sat_iter2_p");
      n_total++; if ({dac0, dac1} !== {14'h3FB0, 14'h0000}) $display("FAIL sat_iter2_p: got %h %h required 3fb0 0000", dac0, dac1); else n_pass++;
      wait_load("sat_iter2_m");
      n_total++; if ({dac0, dac1} !== {14'h3FFF, 14'h0050}) $display("FAIL sat_iter2_m: got %h %h required 3fff 0050", dac0, dac1); else n_pass++;
      wait_done("sat_iter2");
      enable = 1'b0;
      wait_load("sat_iter3_p");
      n_total++; if ({dac0, dac1} !== {14'h0000, 14'h3FB0}) $display("FAIL sat_iter3_p: got %h %h required 0000 3fb0", dac0, dac1); else n_pass++;
      wait_load("sat_iter3_m");
      n_total++; if ({dac0, dac1} !== {14'h0050, 14'h3FFF}) $display("FAIL sat_iter3_m: got %h %h required 0050 3fff", dac0, dac1); else n_pass++;
      wait_done("sat_iter3");
   endtask

   task automatic test_enable_drop();
      int loads = 0;
      do_reset();
      adc_valid = 1'b1;
      adc_data  = 12'h0AA;
      enable    = 1'b1;
      wait_load("drop_apply_p");
      wait_load("drop_apply_m");
      enable = 1'b0;
      wait_done("drop_commit");
      n_total++; if (iter_count !== 16'd1) $display("FAIL drop_count: got %0d required 1", iter_count); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL drop_busy: got %b required 0", busy); else n_pass++;
      for (int k = 0; k < 60; k++) begin
         tick();
         if (dac_load) loads++;
      end
      n_total++; if (loads != 0) $display("FAIL drop_no_load: got %0d loads required 0", loads); else n_pass++;
   endtask

   task automatic test_async_reset();
      do_reset();
      adc_valid = 1'b0;
      adc_data  = 12'h155;
      enable    = 1'b1;
      wait_load("areset_apply_p");
      for (int k = 0; k < S + 3; k++) tick();
      n_total++; if ({busy, dac0, J_p} !== {1'b1, 14'h1FC0, 12'h000}) $display("FAIL areset_pre: got busy=%b dac0=%h J_p=%h required 1 1fc0 000", busy, dac0, J_p); else n_pass++;
      #2;
      rst_n = 1'b0;
      #1;
      n_total++; if ({dac0, dac1} !== {14'h2000, 14'h2000}) $display("FAIL areset_dac: got %h %h required 2000 2000", dac0, dac1); else n_pass++;
      n_total++; if ({DELTA_U0, DELTA_U1} !== 28'h0) $display("FAIL areset_delta: got %h %h required 0 0", DELTA_U0, DELTA_U1); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL areset_busy: got %b required 0", busy); else n_pass++;
      enable = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_count_wrap();
      do_reset();
      force dut.r_iter_count = 16'hFFFF;
      #1;
      release dut.r_iter_count;
      tick();
      n_total++; if (iter_count !== 16'hFFFF) $display("FAIL wrap_preset: got %h required ffff", iter_count); else n_pass++;
      adc_valid = 1'b1;
      adc_data  = 12'h033;
      enable    = 1'b1;
      tick();
      enable = 1'b0;
      wait_done("wrap_commit");
      n_total++; if (iter_count !== 16'h0000) $display("FAIL wrap_count: got %h required 0000", iter_count); else n_pass++;
   endtask

   initial begin
      rst_n     = 1'b0;
      enable    = 1'b0;
      adc_valid = 1'b0;
      adc_data  = 12'h000;
      new_U0    = 14'h2000;
      new_U1    = 14'h2000;
      test_reset();
      test_first_draw();
      test_settle_timing();
      test_update();
      test_saturation();
      test_enable_drop();
      test_async_reset();
      test_count_wrap();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
